// File: rtl/dpsk_pkg.sv
// Shared types and sizing helpers for the DPSK symbol demodulator.
package dpsk_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REF  = 2'd1,
    RUN  = 2'd2
  } demod_state_t;

  // Width needed to hold 0..n-1; never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/dpsk_phase_counter.sv
// Symbol phase counter: counts 0..SPS-1 while enabled, held at 0 while disabled
// so the first enabled cycle always sees phase 0.
module dpsk_phase_counter
  import dpsk_pkg::*;
#(
  parameter int SPS = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  output logic [cnt_w(SPS)-1:0] phase
);

  localparam int PW = cnt_w(SPS);

  logic [PW-1:0] phase_q, phase_d;

  always_comb begin
    phase_d = '0;
    if (en) phase_d = (phase_q == PW'(SPS - 1)) ? '0 : phase_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) phase_q <= '0;
    else     phase_q <= phase_d;
  end

  assign phase = phase_q;

endmodule

// File: rtl/dpsk_symbol_demod.sv
// DPSK demodulator: samples one point per symbol, decodes against the previous
// symbol, and packs decoded bits MSB-first into words behind a valid/ready port.
module dpsk_symbol_demod
  import dpsk_pkg::*;
#(
  parameter int SPS          = 12,
  parameter int SAMPLE_PHASE = 6,
  parameter int WORD_W       = 8,
  parameter int INVERT       = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inbit,
  input  logic              result_out,
  input  logic              word_ready,
  output logic              bit_out,
  output logic              bit_valid,
  output logic [WORD_W-1:0] word_out,
  output logic              word_valid,
  output logic              overrun
);

  localparam int PW = cnt_w(SPS);
  localparam int BW = cnt_w(WORD_W);

  // word_out/word_valid: a word transfers on word_valid & word_ready; word_valid
  // holds until then, and a word completing while a stale one is still pending
  // and not being accepted is dropped and flagged on the sticky overrun.
  logic [PW-1:0] phase;

  dpsk_phase_counter #(.SPS(SPS)) u_phase (
    .clk   (clk),
    .rst   (rst),
    .en    (result_out),
    .phase (phase)
  );

  demod_state_t state_q, state_d;

  logic              sample, ref_take, bit_take, dec_bit, word_done;
  logic              prev_q, prev_d;
  logic [WORD_W-1:0] shift_q, shift_d, full_word;
  logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
  logic              bit_out_q, bit_out_d, bit_valid_q, bit_valid_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic              word_valid_q, word_valid_d, overrun_q, overrun_d;

  assign sample = result_out && (phase == PW'(SAMPLE_PHASE));

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // IDLE with enable high behaves like REF so a phase-0 sample point is not lost.
  always_comb begin
    state_d = state_q;
    if (!result_out) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    state_d = sample ? RUN : REF;
        REF:     state_d = sample ? RUN : REF;
        RUN:     state_d = RUN;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    ref_take = sample && (state_q != RUN);
    bit_take = sample && (state_q == RUN);
  end

  assign dec_bit   = prev_q ^ inbit ^ (INVERT != 0);
  assign word_done = bit_take && (bit_cnt_q == BW'(WORD_W - 1));
  assign full_word = {shift_q[WORD_W-2:0], dec_bit};

  always_comb begin
    prev_d       = prev_q;
    shift_d      = shift_q;
    bit_cnt_d    = bit_cnt_q;
    bit_valid_d  = bit_take;
    bit_out_d    = bit_take & dec_bit;
    word_d       = word_q;
    word_valid_d = word_valid_q;
    overrun_d    = overrun_q;

    if (!result_out) begin
      shift_d   = '0;
      bit_cnt_d = '0;
    end else if (ref_take) begin
      prev_d = inbit;
    end else if (bit_take) begin
      prev_d    = inbit;
      shift_d   = full_word;
      bit_cnt_d = word_done ? '0 : bit_cnt_q + 1'b1;
    end

    if (word_valid_q && word_ready) word_valid_d = 1'b0;
    if (word_done) begin
      if (!word_valid_q || word_ready) begin
        word_d       = full_word;
        word_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q       <= 1'b0;
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      bit_out_q    <= 1'b0;
      bit_valid_q  <= 1'b0;
      word_q       <= '0;
      word_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      prev_q       <= prev_d;
      shift_q      <= shift_d;
      bit_cnt_q    <= bit_cnt_d;
      bit_out_q    <= bit_out_d;
      bit_valid_q  <= bit_valid_d;
      word_q       <= word_d;
      word_valid_q <= word_valid_d;
      overrun_q    <= overrun_d;
    end
  end

  assign bit_out    = bit_out_q;
  assign bit_valid  = bit_valid_q;
  assign word_out   = word_q;
  assign word_valid = word_valid_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_dpsk_symbol_demod.sv
// Directed bench for dpsk_symbol_demod (normal and inverted instances) with
// queued expectations checked by an output monitor.
module tb_dpsk_symbol_demod;

  localparam int SPS = 12;
  localparam int SP  = 6;
  localparam int WW  = 8;

  logic clk = 1'b0;
  logic rst, inbit, result_out, word_ready;
  logic bit_out, bit_valid, word_valid, overrun;
  logic [WW-1:0] word_out;
  logic bit_out_i, bit_valid_i, word_valid_i, overrun_i;
  logic [WW-1:0] word_out_i;

  int checks = 0;
  int errors = 0;
  int t = 0;
  int t0 = 0;

  // {relative cycle, bit} and {relative cycle, word}
  logic [16:0] exp_q[$];
  logic [16:0] exp_inv_q[$];
  logic [23:0] exp_w_q[$];
  logic [15:0] exp_ov_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) t <= t + 1;

  dpsk_symbol_demod #(.SPS(SPS), .SAMPLE_PHASE(SP), .WORD_W(WW), .INVERT(0)) u_dut (
    .clk(clk), .rst(rst), .inbit(inbit), .result_out(result_out), .word_ready(word_ready),
    .bit_out(bit_out), .bit_valid(bit_valid), .word_out(word_out),
    .word_valid(word_valid), .overrun(overrun)
  );

  dpsk_symbol_demod #(.SPS(SPS), .SAMPLE_PHASE(SP), .WORD_W(WW), .INVERT(1)) u_dut_inv (
    .clk(clk), .rst(rst), .inbit(inbit), .result_out(result_out), .word_ready(word_ready),
    .bit_out(bit_out_i), .bit_valid(bit_valid_i), .word_out(word_out_i),
    .word_valid(word_valid_i), .overrun(overrun_i)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0d)", name, act, exp, t);
    end
  endtask

  // Output monitor
  logic wv_prev_q = 1'b0, took_q = 1'b0, ov_prev_q = 1'b0, bv_prev_q = 1'b0;
  always @(posedge clk) begin
    wv_prev_q <= word_valid;
    took_q    <= word_valid && word_ready;
    ov_prev_q <= overrun;
    bv_prev_q <= bit_valid;
  end

  always @(negedge clk) begin
    logic [15:0] rel;
    logic [16:0] e;
    logic [23:0] ew;
    rel = 16'(t - t0);
    if (bit_valid === 1'b1) begin
      check("bit_valid_not_back_to_back", {31'd0, bv_prev_q}, 32'd0);
      if (exp_q.size() == 0) check("unexpected_bit_valid", {16'd0, rel}, 32'hffff);
      else begin
        e = exp_q.pop_front();
        check("bit_cycle_and_value", {15'd0, rel, bit_out}, {15'd0, e});
      end
    end
    if (bit_valid_i === 1'b1) begin
      if (exp_inv_q.size() == 0) check("unexpected_bit_valid_inv", {16'd0, rel}, 32'hffff);
      else begin
        e = exp_inv_q.pop_front();
        check("inv_bit_cycle_and_value", {15'd0, rel, bit_out_i}, {15'd0, e});
      end
    end
    if (word_valid === 1'b1 && (!wv_prev_q || took_q)) begin
      if (exp_w_q.size() == 0) check("unexpected_word", {16'd0, rel}, 32'hffff);
      else begin
        ew = exp_w_q.pop_front();
        check("word_cycle_and_value", {8'd0, rel, word_out}, {8'd0, ew});
        check("word_with_bit_valid", {31'd0, bit_valid}, 32'd1);
      end
    end
    if (overrun === 1'b1 && !ov_prev_q) begin
      if (exp_ov_q.size() == 0) check("unexpected_overrun", {16'd0, rel}, 32'hffff);
      else check("overrun_rise_cycle", {16'd0, rel}, {16'd0, exp_ov_q.pop_front()});
    end
  end

  // Enable and drive n symbols (syms MSB first); queue the hand-computed bits.
  // With cut_last, enable drops exactly on the last symbol's sample cycle.
  task automatic send(input int n, input logic [31:0] syms, input logic [31:0] bits,
                      input bit cut_last);
    logic b;
    @(negedge clk);
    result_out = 1'b1;
    t0 = t;
    for (int i = 0; i < n; i++) begin
      if (i >= 1 && !(cut_last && i == n - 1)) begin
        b = bits[n - 1 - i];
        exp_q.push_back({16'(SPS * i + SP + 1), b});
        exp_inv_q.push_back({16'(SPS * i + SP + 1), ~b});
      end
      for (int j = 0; j < SPS; j++) begin
        if (cut_last && i == n - 1 && j == SP) break;
        if (!(i == 0 && j == 0)) @(negedge clk);
        if (j == 0) inbit = syms[n - 1 - i];
      end
    end
    @(negedge clk);
    result_out = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) begin
      @(negedge clk);
      inbit = ~inbit;
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; inbit = 1'b0; result_out = 1'b0; word_ready = 1'b0;

    // Reset with toggling input, then a long idle stretch.
    repeat (2) begin
      @(negedge clk);
      inbit = ~inbit;
      check("rst_bit_out", {31'd0, bit_out}, 32'd0);
      check("rst_bit_valid", {31'd0, bit_valid}, 32'd0);
      check("rst_word_out", {24'd0, word_out}, 32'd0);
      check("rst_word_valid", {31'd0, word_valid}, 32'd0);
      check("rst_overrun", {31'd0, overrun}, 32'd0);
    end
    rst = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      inbit = ~inbit;
      check("idle_no_bit_valid", {31'd0, bit_valid}, 32'd0);
    end

    // Basic decode: symbols 1,1,0,0,1 -> 0,1,0,1 (inverted 1,0,1,0).
    send(5, 32'b11001, 32'b0101, 1'b0);
    repeat (5) @(negedge clk);

    // Word packing: ref 0 then bits 10110010, consumer stalled.
    exp_w_q.push_back({16'(SPS * 8 + SP + 1), 8'hB2});
    send(9, 32'b011011100, 32'b10110010, 1'b0);
    repeat (3) @(negedge clk);
    check("pending_word_valid_kept", {31'd0, word_valid}, 32'd1);
    check("pending_word_out_kept", {24'd0, word_out}, 32'hB2);
    word_ready = 1'b1;
    @(negedge clk);
    word_ready = 1'b0;
    check("word_valid_falls_after_accept", {31'd0, word_valid}, 32'd0);

    // Overrun: two words with no consumer; second word is dropped.
    do_reset();
    exp_w_q.push_back({16'(SPS * 8 + SP + 1), 8'hB2});
    exp_ov_q.push_back(16'(SPS * 16 + SP + 1));
    send(17, 32'b01101110000001010, 32'b1011001000001111, 1'b0);
    check("overrun_set", {31'd0, overrun}, 32'd1);
    check("overrun_word_kept", {24'd0, word_out}, 32'hB2);
    check("overrun_word_valid", {31'd0, word_valid}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_clears_overrun", {31'd0, overrun}, 32'd0);
    check("rst_clears_word_valid", {31'd0, word_valid}, 32'd0);
    check("rst_clears_word_out", {24'd0, word_out}, 32'd0);

    // Disable mid-word, dropping enable on a sample cycle, then a fresh word.
    word_ready = 1'b1;
    send(4, 32'b0111, 32'b100, 1'b1);
    repeat (20) @(negedge clk);
    exp_w_q.push_back({16'(SPS * 8 + SP + 1), 8'h5A});
    send(9, 32'b110010011, 32'b01011010, 1'b0);
    check("accepted_word_valid_low", {31'd0, word_valid}, 32'd0);
    check("fresh_word_out", {24'd0, word_out}, 32'h5A);
    word_ready = 1'b0;

    repeat (30) @(negedge clk);
    check("bit_queue_drained", exp_q.size(), 32'd0);
    check("inv_bit_queue_drained", exp_inv_q.size(), 32'd0);
    check("word_queue_drained", exp_w_q.size(), 32'd0);
    check("overrun_queue_drained", exp_ov_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
